axi4_w_sender: RTL and testbench

- Sequencer for the write-data path between the W input buffer and the downstream master port.
- Holds W beats until the address-side translation decision for the matching AW burst arrives.
- Each decided burst is either forwarded unchanged or drained and discarded.
- Each drop is reported to the B-channel responder, which then issues an error response.

---
 rtl/axi4_w_sender.sv | 155 +++++++++++++++
 tb/tb_axi4_w_sender.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_w_sender.sv
// W-channel sequencer: holds W beats until the AW decision arrives, then
// forwards the burst or drains it and reports the drop to the B responder.
//
// Ports:
//   axi4_aclk, axi4_arstn  clock, synchronous active-low reset
//   cmd_*                  burst decisions {drop, id} into a small FIFO
//   s_axi4_w*              upstream W channel (from the W input buffer)
//   m_axi4_w*              downstream W channel (to the master port)
//   drop_*                 dropped-burst report to the B responder
//   busy                   FSM active or decisions pending
module axi4_w_sender #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int CMD_DEPTH      = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_drop,
  input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                        drop_valid,
  input  logic                        drop_ready,
  output logic [AXI_ID_WIDTH-1:0]     drop_id,
  output logic                        busy
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP,
    REPORT
  } state_t;

  state_t state;

  logic [PW-1:0]           wp;
  logic [PW-1:0]           rp;
  logic                    fdrop [CMD_DEPTH];
  logic [AXI_ID_WIDTH-1:0] fid   [CMD_DEPTH];
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic [AXI_ID_WIDTH-1:0] id_q;
  logic [8:0]              beat_cnt;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // Gated by reset so no slot is advertised while held in reset.
  assign cmd_ready = axi4_arstn && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        fdrop[i] <= 1'b0;
        fid[i]   <= '0;
      end
    end else begin
      if (push) begin
        fdrop[wp[AW-1:0]] <= cmd_drop;
        fid[wp[AW-1:0]]   <= cmd_id;
        wp                <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
    end
  end

  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      state    <= IDLE;
      id_q     <= '0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            id_q  <= fid[rp[AW-1:0]];
            state <= fdrop[rp[AW-1:0]] ? DROP : FWD;
          end
        end
        FWD: begin
          if (s_axi4_wvalid && m_axi4_wready) begin
            if (s_axi4_wlast) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else if (beat_cnt != 9'd256) begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        DROP: begin
          if (s_axi4_wvalid) begin
            if (s_axi4_wlast) begin
              state    <= REPORT;
              beat_cnt <= '0;
            end else if (beat_cnt != 9'd256) begin
              beat_cnt <= beat_cnt + 9'd1;
            end
          end
        end
        REPORT: begin
          if (drop_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Beat count is debug-only; wlast alone closes a burst.
  a_beat_sat: assert property (
    @(posedge axi4_aclk) disable iff (!axi4_arstn)
    beat_cnt <= 9'd256
  );

  assign s_axi4_wready = (state == FWD) ? m_axi4_wready
                                        : (state == DROP);
  assign m_axi4_wvalid = (state == FWD) && s_axi4_wvalid;
  assign m_axi4_wdata  = s_axi4_wdata;
  assign m_axi4_wstrb  = s_axi4_wstrb;
  assign m_axi4_wlast  = s_axi4_wlast;
  assign m_axi4_wuser  = s_axi4_wuser;

  assign drop_valid = (state == REPORT);
  assign drop_id    = id_q;
  assign busy       = (state != IDLE) || !empty;

endmodule

// File: tb/tb_axi4_w_sender.sv
// Bench for axi4_w_sender: per-cycle vector table for forward, drop and
// backpressure bursts, plus sequences for FIFO full, early data and reset.
module tb_axi4_w_sender;

  logic        axi4_aclk = 1'b0;
  logic        axi4_arstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_drop;
  logic [3:0]  cmd_id;
  logic [31:0] s_axi4_wdata;
  logic        s_axi4_wvalid;
  logic        s_axi4_wready;
  logic [3:0]  s_axi4_wstrb;
  logic        s_axi4_wlast;
  logic [3:0]  s_axi4_wuser;
  logic [31:0] m_axi4_wdata;
  logic        m_axi4_wvalid;
  logic        m_axi4_wready;
  logic [3:0]  m_axi4_wstrb;
  logic        m_axi4_wlast;
  logic [3:0]  m_axi4_wuser;
  logic        drop_valid;
  logic        drop_ready;
  logic [3:0]  drop_id;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 axi4_aclk = ~axi4_aclk;

  axi4_w_sender dut (
    .axi4_aclk     (axi4_aclk),
    .axi4_arstn    (axi4_arstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_drop      (cmd_drop),
    .cmd_id        (cmd_id),
    .s_axi4_wdata  (s_axi4_wdata),
    .s_axi4_wvalid (s_axi4_wvalid),
    .s_axi4_wready (s_axi4_wready),
    .s_axi4_wstrb  (s_axi4_wstrb),
    .s_axi4_wlast  (s_axi4_wlast),
    .s_axi4_wuser  (s_axi4_wuser),
    .m_axi4_wdata  (m_axi4_wdata),
    .m_axi4_wvalid (m_axi4_wvalid),
    .m_axi4_wready (m_axi4_wready),
    .m_axi4_wstrb  (m_axi4_wstrb),
    .m_axi4_wlast  (m_axi4_wlast),
    .m_axi4_wuser  (m_axi4_wuser),
    .drop_valid    (drop_valid),
    .drop_ready    (drop_ready),
    .drop_id       (drop_id),
    .busy          (busy)
  );

  typedef struct {
    logic        cv;
    logic        cd;
    logic [3:0]  cid;
    logic        wv;
    logic [31:0] wd;
    logic        wl;
    logic        mr;
    logic        dr;
    logic        e_crdy;
    logic        e_swr;
    logic        e_mwv;
    logic        e_dv;
    logic [3:0]  e_did;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic cv, input logic cd, input logic [3:0] cid,
    input logic wv, input logic [31:0] wd, input logic wl,
    input logic mr, input logic dr,
    input logic ecr, input logic esw, input logic emv,
    input logic edv, input logic [3:0] edid, input logic eb
  );
    vec_t v;
    v.cv = cv; v.cd = cd; v.cid = cid;
    v.wv = wv; v.wd = wd; v.wl = wl;
    v.mr = mr; v.dr = dr;
    v.e_crdy = ecr; v.e_swr = esw; v.e_mwv = emv;
    v.e_dv = edv; v.e_did = edid; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge axi4_aclk);
    #1;
  endtask

  task automatic drv_w(input logic v, input logic [31:0] d,
                       input logic l);
    s_axi4_wvalid = v;
    s_axi4_wdata  = d;
    s_axi4_wstrb  = d[3:0];
    s_axi4_wuser  = d[7:4];
    s_axi4_wlast  = l;
  endtask

  task automatic drv_c(input logic v, input logic d,
                       input logic [3:0] id);
    cmd_valid = v;
    cmd_drop  = d;
    cmd_id    = id;
  endtask

  task automatic chk_fwd(input string nm, input logic [31:0] d,
                         input logic l);
    chk({nm, "_mwv"}, m_axi4_wvalid, 1);
    chk({nm, "_mdata"}, m_axi4_wdata, d);
    chk({nm, "_mlast"}, m_axi4_wlast, l);
  endtask

  // One single-beat burst for the decision already in the FSM, then the
  // IDLE bubble in which the next decision is popped.
  task automatic serve(input logic exp_drop, input logic [3:0] id,
                       input logic [31:0] d);
    drv_w(1, d, 1);
    m_axi4_wready = 1;
    drop_ready = 1;
    @(negedge axi4_aclk);
    chk($sformatf("srv%0d_swr", id), s_axi4_wready, 1);
    chk($sformatf("srv%0d_mwv", id), m_axi4_wvalid, !exp_drop);
    chk($sformatf("srv%0d_crdy", id), cmd_ready, 1);
    if (!exp_drop) chk($sformatf("srv%0d_mdata", id), m_axi4_wdata, d);
    nxt();
    drv_w(0, 0, 0);
    if (exp_drop) begin
      @(negedge axi4_aclk);
      chk($sformatf("srv%0d_dv", id), drop_valid, 1);
      chk($sformatf("srv%0d_did", id), drop_id, id);
      nxt();
    end
    @(negedge axi4_aclk);
    chk($sformatf("srv%0d_dv_off", id), drop_valid, 0);
    chk($sformatf("srv%0d_swr_idle", id), s_axi4_wready, 0);
    nxt();
    drop_ready = 0;
  endtask

  initial begin
    axi4_arstn = 0;
    drv_c(0, 0, 0);
    drv_w(0, 0, 0);
    m_axi4_wready = 0;
    drop_ready = 0;

    // forward 4 beats, id 3
    tbl.push_back(mk(1,0,3, 0,32'h0,0, 1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,32'hA0,0, 1,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hA0,0, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hA1,0, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hA2,0, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hA3,1, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,0,0,0));
    // drop 2 beats, id 5, report held 3 cycles
    tbl.push_back(mk(1,1,5, 0,32'h0,0, 1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,32'hB0,0, 1,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hB0,0, 0,0, 1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hB1,1, 0,0, 1,1,0,0,0,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,1,5,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,1,5,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,1,5,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,1, 1,0,0,1,5,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,0,0,0));
    // backpressure 1,0,0,1 on a 2-beat forward burst
    tbl.push_back(mk(1,0,7, 0,32'h0,0, 1,0, 1,0,0,0,0,0));
    tbl.push_back(mk(0,0,0, 1,32'hC0,0, 1,0, 1,0,0,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hC0,0, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hC1,1, 0,0, 1,0,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hC1,1, 0,0, 1,0,1,0,0,1));
    tbl.push_back(mk(0,0,0, 1,32'hC1,1, 1,0, 1,1,1,0,0,1));
    tbl.push_back(mk(0,0,0, 0,32'h0,0, 1,0, 1,0,0,0,0,0));

    // reset state
    nxt();
    @(negedge axi4_aclk);
    chk("rst_crdy", cmd_ready, 0);
    chk("rst_swr", s_axi4_wready, 0);
    chk("rst_mwv", m_axi4_wvalid, 0);
    chk("rst_dv", drop_valid, 0);
    chk("rst_did", drop_id, 0);
    chk("rst_busy", busy, 0);
    nxt();
    axi4_arstn = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      drv_c(tbl[i].cv, tbl[i].cd, tbl[i].cid);
      drv_w(tbl[i].wv, tbl[i].wd, tbl[i].wl);
      m_axi4_wready = tbl[i].mr;
      drop_ready = tbl[i].dr;
      @(negedge axi4_aclk);
      chk($sformatf("v%0d_crdy", i), cmd_ready, tbl[i].e_crdy);
      chk($sformatf("v%0d_swr", i), s_axi4_wready, tbl[i].e_swr);
      chk($sformatf("v%0d_mwv", i), m_axi4_wvalid, tbl[i].e_mwv);
      chk($sformatf("v%0d_dv", i), drop_valid, tbl[i].e_dv);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_dv)
        chk($sformatf("v%0d_did", i), drop_id, tbl[i].e_did);
      if (tbl[i].e_mwv) begin
        chk($sformatf("v%0d_mdata", i), m_axi4_wdata, tbl[i].wd);
        chk($sformatf("v%0d_mstrb", i), m_axi4_wstrb, tbl[i].wd[3:0]);
        chk($sformatf("v%0d_muser", i), m_axi4_wuser, tbl[i].wd[7:4]);
        chk($sformatf("v%0d_mlast", i), m_axi4_wlast, tbl[i].wl);
      end
      nxt();
    end
    drv_c(0, 0, 0);
    drv_w(0, 0, 0);
    drop_ready = 0;

    // FIFO full: park FSM in FWD on id 0, then queue ids 1..4
    drv_c(1, 0, 0);
    nxt();
    drv_c(0, 0, 0);
    nxt();
    for (int i = 1; i <= 4; i++) begin
      drv_c(1, (i % 2) == 0, 4'(i));
      @(negedge axi4_aclk);
      chk($sformatf("full_push%0d_crdy", i), cmd_ready, 1);
      nxt();
    end
    drv_c(1, 1, 9);
    @(negedge axi4_aclk);
    chk("full_crdy", cmd_ready, 0);
    chk("full_busy", busy, 1);
    nxt();
    drv_c(0, 0, 0);
    drv_w(1, 32'hD0, 1);
    m_axi4_wready = 1;
    @(negedge axi4_aclk);
    chk("full_id0_swr", s_axi4_wready, 1);
    chk_fwd("full_id0", 32'hD0, 1);
    nxt();
    drv_w(0, 0, 0);
    @(negedge axi4_aclk);
    chk("full_pop_crdy", cmd_ready, 0);
    nxt();
    serve(0, 1, 32'hD1);
    serve(1, 2, 32'hD2);
    serve(0, 3, 32'hD3);
    serve(1, 4, 32'hD4);
    @(negedge axi4_aclk);
    chk("full_end_busy", busy, 0);
    chk("full_end_dv", drop_valid, 0);
    nxt();

    // early data: beats wait in IDLE until a decision arrives
    drv_w(1, 32'hE0, 1);
    m_axi4_wready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge axi4_aclk);
      chk($sformatf("early%0d_swr", i), s_axi4_wready, 0);
      chk($sformatf("early%0d_mwv", i), m_axi4_wvalid, 0);
      nxt();
    end
    drv_c(1, 0, 6);
    @(negedge axi4_aclk);
    chk("early_push_swr", s_axi4_wready, 0);
    nxt();
    drv_c(0, 0, 0);
    @(negedge axi4_aclk);
    chk("early_pop_swr", s_axi4_wready, 0);
    chk("early_pop_busy", busy, 1);
    nxt();
    @(negedge axi4_aclk);
    chk("early_hs_swr", s_axi4_wready, 1);
    chk_fwd("early_hs", 32'hE0, 1);
    nxt();
    drv_w(0, 0, 0);
    @(negedge axi4_aclk);
    chk("early_end_busy", busy, 0);
    nxt();

    // reset after beat 2 of a forward burst, two decisions queued
    drv_c(1, 0, 8);
    nxt();
    drv_c(1, 1, 9);
    nxt();
    drv_c(1, 0, 10);
    nxt();
    drv_c(0, 0, 0);
    drv_w(1, 32'hF0, 0);
    @(negedge axi4_aclk);
    chk_fwd("mid_b0", 32'hF0, 0);
    nxt();
    drv_w(1, 32'hF1, 0);
    @(negedge axi4_aclk);
    chk_fwd("mid_b1", 32'hF1, 0);
    nxt();
    axi4_arstn = 0;
    drv_w(1, 32'hF2, 0);
    nxt();
    axi4_arstn = 1;
    @(negedge axi4_aclk);
    chk("mid_crdy", cmd_ready, 1);
    chk("mid_swr", s_axi4_wready, 0);
    chk("mid_mwv", m_axi4_wvalid, 0);
    chk("mid_dv", drop_valid, 0);
    chk("mid_did", drop_id, 0);
    chk("mid_busy", busy, 0);
    nxt();
    for (int i = 0; i < 3; i++) begin
      @(negedge axi4_aclk);
      chk($sformatf("mid_idle%0d_dv", i), drop_valid, 0);
      chk($sformatf("mid_idle%0d_busy", i), busy, 0);
      nxt();
    end
    drv_c(1, 0, 11);
    nxt();
    drv_c(0, 0, 0);
    nxt();
    @(negedge axi4_aclk);
    chk_fwd("mid_f2", 32'hF2, 0);
    nxt();
    drv_w(1, 32'hF3, 1);
    @(negedge axi4_aclk);
    chk_fwd("mid_f3", 32'hF3, 1);
    nxt();
    drv_w(0, 0, 0);
    @(negedge axi4_aclk);
    chk("mid_end_busy", busy, 0);
    chk("mid_end_dv", drop_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
